// File: rtl/counter_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : counter_run_controller
// Description : Sequencer for a bounded, prescaled up/down step-counter run
//               with pause, abort and busy/done/aborted status. Defining
//               AUTO_RELOAD_EN adds a reload input that restarts from DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_run_controller #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] terminal,
    input  logic             up_down,
    input  logic             pause,
    input  logic             abort,
`ifdef AUTO_RELOAD_EN
    input  logic             reload,
`endif
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int               c_PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0]  c_PS_LAST = c_PW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_count,   w_count_nxt;
    logic [c_PW-1:0]  r_presc,   w_presc_nxt;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_term;
    logic             r_dir;
    logic             r_aborted, w_aborted_nxt;
    logic             w_capture;
    logic             w_step;
    logic             w_reload;

`ifdef AUTO_RELOAD_EN
    assign w_reload = reload;
`else
    assign w_reload = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_presc_nxt   = r_presc;
        w_aborted_nxt = 1'b0;
        w_capture     = 1'b0;
        w_step        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_load;
                w_presc_nxt = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_count == r_term) begin
                    w_state_nxt = S_DONE;
                end else if (pause) begin
                    w_state_nxt = S_PAUSED;
                end else if (r_presc == c_PS_LAST) begin
                    w_step      = 1'b1;
                    w_count_nxt = r_dir ? (r_count + 1'b1) : (r_count - 1'b1);
                    w_presc_nxt = '0;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            S_PAUSED: begin
                if (!pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (w_reload) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over everything except reset; count and prescaler freeze.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_count_nxt   = r_count;
            w_presc_nxt   = r_presc;
            w_capture     = 1'b0;
            w_step        = 1'b0;
            w_aborted_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_presc   <= '0;
            r_load    <= '0;
            r_term    <= '0;
            r_dir     <= 1'b1;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_presc   <= w_presc_nxt;
            r_aborted <= w_aborted_nxt;
            if (w_capture) begin
                r_load <= load_value;
                r_term <= terminal;
                r_dir  <= up_down;
            end
        end
    end

    assign count   = r_count;
    assign step    = w_step;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign aborted = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_counter_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_run_controller
// Description : Directed scoreboard bench; one DIV=1 and one DIV=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_run_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] load_value;
    logic [3:0] terminal;
    logic       up_down;
    logic       pause;
    logic       abort;
`ifdef AUTO_RELOAD_EN
    logic       reload;
`endif

    logic [3:0] count1, count3;
    logic       step1, busy1, done1, ab1;
    logic       step3, busy3, done3, ab3;

    logic       sel;
    logic [3:0] obs_count;
    logic       obs_step, obs_busy, obs_done, obs_ab;

    assign obs_count = sel ? count3 : count1;
    assign obs_step  = sel ? step3  : step1;
    assign obs_busy  = sel ? busy3  : busy1;
    assign obs_done  = sel ? done3  : done1;
    assign obs_ab    = sel ? ab3    : ab1;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    logic [5:0] arq[$];

    counter_run_controller #(.WIDTH(4), .DIV(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .load_value(load_value),
        .terminal(terminal), .up_down(up_down), .pause(pause), .abort(abort),
`ifdef AUTO_RELOAD_EN
        .reload(reload),
`endif
        .count(count1), .step(step1), .busy(busy1), .done(done1), .aborted(ab1)
    );

    counter_run_controller #(.WIDTH(4), .DIV(3)) u_dut3 (
        .clock(clock), .reset(reset), .start(start), .load_value(load_value),
        .terminal(terminal), .up_down(up_down), .pause(pause), .abort(abort),
`ifdef AUTO_RELOAD_EN
        .reload(reload),
`endif
        .count(count3), .step(step3), .busy(busy3), .done(done3), .aborted(ab3)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (busy1 || busy3); i++) cyc();
        chk("idle_wait", {31'd0, busy1 | busy3}, 0);
    endtask

    // Runs one bounded count and checks every count value against the queue.
    task automatic run(input logic s, input logic [3:0] ld, input logic [3:0] tm,
                       input logic dir, input int div, input bit disturb, input bit ab_start);
        logic [3:0] v;
        logic [3:0] prev;
        logic       st;
        int         nsteps, steps, since;
        bit         finished;
        wait_idle();
        sel = s;
        exp_q.delete();
        v = ld;
        exp_q.push_back(v);
        nsteps = 0;
        while (v != tm) begin
            v = dir ? v + 4'd1 : v - 4'd1;
            exp_q.push_back(v);
            nsteps++;
        end
        load_value = ld; terminal = tm; up_down = dir; start = 1'b1; abort = ab_start;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("load_busy", obs_busy, 1);
        chk("load_aborted", obs_ab, 0);
        cyc();
        chk("first_count", obs_count, exp_q.pop_front());
        prev = obs_count; since = 0; steps = 0; finished = 0;
        for (int i = 0; i < 200 && !finished; i++) begin
            if (exp_q.size() == 0) begin
                chk("no_step_at_terminal", obs_step, 0);
                cyc();
                chk("done_after_terminal", obs_done, 1);
                chk("done_count", obs_count, tm);
                finished = 1;
            end else begin
                chk("done_early", obs_done, 0);
                st = obs_step;
                if (disturb && i == 1) begin
                    start = 1'b1; load_value = ~ld; terminal = ~tm; up_down = ~dir;
                end
                cyc();
                start = 1'b0;
                since++;
                if (st) begin
                    steps++;
                    chk("count", obs_count, exp_q.pop_front());
                    chk("step_interval", since, div);
                    since = 0;
                end else begin
                    chk("hold", obs_count, prev);
                end
                prev = obs_count;
            end
        end
        chk("run_finished", {31'd0, finished}, 1);
        cyc();
        chk("busy_after_done", obs_busy, 0);
        chk("done_pulse_once", obs_done, 0);
        chk("step_total", steps, nsteps);
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; start = 1'b0; load_value = '0; terminal = '0;
        up_down = 1'b1; pause = 1'b0; abort = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload = 1'b0;
`endif
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_count", obs_count, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_done", obs_done, 0);
        chk("rst_aborted", obs_ab, 0);
        chk("rst_step", obs_step, 0);
        chk("rst_count_div3", count3, 0);

        // Reset held two cycles in the middle of a run
        load_value = 4'd5; terminal = 4'd12; up_down = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("pre_reset_count", obs_count, 5);
        reset = 1'b1;
        cyc();
        chk("mid_reset_count", obs_count, 0);
        chk("mid_reset_busy", obs_busy, 0);
        cyc();
        reset = 1'b0;
        chk("mid_reset_done", obs_done, 0);
        cyc();
        chk("post_reset_count", obs_count, 0);
        chk("post_reset_busy", obs_busy, 0);

        run(1'b0, 4'd3,  4'd7,  1'b1, 1, 1'b0, 1'b0);   // basic up
        run(1'b0, 4'd1,  4'd14, 1'b0, 1, 1'b0, 1'b0);   // down through wrap
        run(1'b0, 4'd14, 4'd1,  1'b1, 1, 1'b0, 1'b0);   // up through wrap
        run(1'b1, 4'd0,  4'd2,  1'b1, 3, 1'b0, 1'b0);   // prescaled
        run(1'b0, 4'd0,  4'd5,  1'b1, 1, 1'b1, 1'b0);   // start while busy
        run(1'b0, 4'd9,  4'd9,  1'b1, 1, 1'b0, 1'b1);   // zero steps, abort in IDLE

        // Pause mid-prescale then abort, on the DIV=3 instance
        wait_idle();
        sel = 1'b1;
        load_value = 4'd3; terminal = 4'd9; up_down = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("pa_load", obs_count, 3);
        cyc(); cyc(); cyc();
        chk("pa_first_step", obs_count, 4);
        cyc();
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("pause_hold", obs_count, 4);
            chk("pause_step", obs_step, 0);
        end
        pause = 1'b0;
        cyc();
        chk("resume_step0", obs_step, 0);
        cyc();
        chk("resume_step1", obs_step, 1);
        chk("resume_count", obs_count, 4);
        cyc();
        chk("resume_next", obs_count, 5);
        cyc(); cyc(); cyc();
        chk("pre_abort", obs_count, 6);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_count", obs_count, 6);
        chk("abort_busy", obs_busy, 0);
        chk("abort_pulse", obs_ab, 1);
        chk("abort_done", obs_done, 0);
        cyc();
        chk("abort_pulse_end", obs_ab, 0);
        chk("abort_count_hold", obs_count, 6);

`ifdef AUTO_RELOAD_EN
        wait_idle();
        sel = 1'b0;
        arq.delete();
        arq.push_back({4'd0, 1'b0, 1'b1}); arq.push_back({4'd1, 1'b0, 1'b1});
        arq.push_back({4'd2, 1'b0, 1'b1}); arq.push_back({4'd2, 1'b1, 1'b1});
        arq.push_back({4'd2, 1'b0, 1'b1}); arq.push_back({4'd0, 1'b0, 1'b1});
        arq.push_back({4'd1, 1'b0, 1'b1}); arq.push_back({4'd2, 1'b0, 1'b1});
        arq.push_back({4'd2, 1'b1, 1'b1}); arq.push_back({4'd2, 1'b0, 1'b0});
        reload = 1'b1; load_value = 4'd0; terminal = 4'd2; up_down = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("reload_seq", {obs_count, obs_done, obs_busy}, arq.pop_front());
            if (k == 7) reload = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
